// File: rtl/serial_pattern_matcher_if.sv
// Pad-side bus for serial_pattern_matcher: the standard 8-in/8-out user
// module wrapper. io_in[0] is the clock and io_in[1] the active-low reset;
// both ride the bus because the pad wrapper delivers them that way.
interface serial_pattern_matcher_if;
    logic [7:0] io_in;
    logic [7:0] io_out;

    // Pad wrapper / testbench side
    modport master (
        output io_in,
        input  io_out
    );

    // User module side
    modport slave (
        input  io_in,
        output io_out
    );
endinterface

// File: rtl/serial_pattern_matcher.sv
// serial_pattern_matcher: shifts a serial stream into a PAT_LEN-bit window
// and compares it against a run-time loadable pattern. A fill guard keeps the
// compare quiet until PAT_LEN fresh bits are in; overlapping matches are seen.
// A sticky flag and a saturating counter summarise match activity.
//
// Optional build macro PATMATCH_MASK_EN adds a per-bit don't-care mask that is
// loaded serially alongside the pattern from io_in[4]. Without it the compare
// is exact and io_in[4] is ignored.
//
// Pad map: io_in  = {unused[1:0], clr_cnt, mask_in, mode, din, rst_n, clk}
//          io_out = {count[5:0], sticky, match}
module serial_pattern_matcher #(
    parameter int                 PAT_LEN       = 44,
    parameter logic [PAT_LEN-1:0] RESET_PATTERN = '0,
    parameter int                 CNT_W         = 6
) (
    serial_pattern_matcher_if.slave bus
);

    localparam int                FILL_W    = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
    // Compare is armed once the window already holds PAT_LEN-1 valid bits,
    // so the bit being sampled completes a full window.
    localparam logic [FILL_W-1:0] FILL_ARM  = FILL_W'(PAT_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef struct packed {
        logic clr_cnt;
        logic mask_in;
        logic mode;
        logic din;
        logic rst_n;
    } pad_in_t;

    logic    clk;
    pad_in_t pin;

    assign clk = bus.io_in[0];
    assign pin = pad_in_t'(bus.io_in[5:1]);

    logic [PAT_LEN-1:0] window_q;
    logic [PAT_LEN-1:0] window_nxt;
    logic [PAT_LEN-1:0] pattern_q;
    logic [PAT_LEN-1:0] mask;
    logic [FILL_W-1:0]  fill_q;
    logic               match_q;
    logic               sticky_q;
    logic [CNT_W-1:0]   count_q;

    logic               hit;
    logic               match_set;
    logic               sticky_base;
    logic [CNT_W-1:0]   count_base;
    logic [CNT_W-1:0]   count_nxt;
    logic [5:0]         count_ext;

`ifdef PATMATCH_MASK_EN
    logic [PAT_LEN-1:0] mask_q;
    logic               unused_pads;

    // Mask shifts in lockstep with the pattern; reset leaves every bit compared.
    always_ff @(posedge clk) begin
        if (!pin.rst_n) begin
            mask_q <= '1;
        end else if (pin.mode) begin
            mask_q <= {mask_q[PAT_LEN-2:0], pin.mask_in};
        end
    end

    assign mask        = mask_q;
    assign unused_pads = ^bus.io_in[7:6];
`else
    logic unused_pads;

    assign mask        = '1;
    assign unused_pads = ^{bus.io_in[7:6], pin.mask_in};
`endif

    // Candidate window and masked compare against the pattern.
    always_comb begin
        window_nxt = {window_q[PAT_LEN-2:0], pin.din};
        hit        = (fill_q >= FILL_ARM) &&
                     (((window_nxt ^ pattern_q) & mask) == '0);
    end

    // Detect shifts the window; load shifts the pattern and flushes the window
    // so detection restarts from an empty fill after returning to detect.
    always_ff @(posedge clk) begin
        if (!pin.rst_n) begin
            window_q  <= '0;
            fill_q    <= '0;
            match_q   <= 1'b0;
            pattern_q <= RESET_PATTERN;
        end else if (pin.mode) begin
            pattern_q <= {pattern_q[PAT_LEN-2:0], pin.din};
            window_q  <= '0;
            fill_q    <= '0;
            match_q   <= 1'b0;
        end else begin
            window_q <= window_nxt;
            if (fill_q != FILL_FULL) begin
                fill_q <= fill_q + FILL_W'(1);
            end
            match_q <= hit;
        end
    end

    // Clear is applied before the increment, so clear plus match gives one.
    always_comb begin
        match_set   = !pin.mode && hit;
        sticky_base = pin.clr_cnt ? 1'b0 : sticky_q;
        count_base  = pin.clr_cnt ? '0 : count_q;
        count_nxt   = count_base;
        if (match_set && (count_base != CNT_MAX)) begin
            count_nxt = count_base + CNT_W'(1);
        end
    end

    // Status registers; retained across load mode apart from an explicit clear.
    always_ff @(posedge clk) begin
        if (!pin.rst_n) begin
            sticky_q <= 1'b0;
            count_q  <= '0;
        end else begin
            sticky_q <= sticky_base | match_set;
            count_q  <= count_nxt;
        end
    end

    // Zero-extend the counter onto the six upper pads.
    always_comb begin
        count_ext             = '0;
        count_ext[CNT_W-1:0]  = count_q;
    end

    assign bus.io_out = {count_ext, sticky_q, match_q};

endmodule

// File: tb/tb_serial_pattern_matcher.sv
// Self-checking bench for serial_pattern_matcher (PAT_LEN=8, reset pattern A5).
// Every cycle a reference model predicts io_out and pushes it to a scoreboard;
// after the edge the DUT output is popped and compared. Scenario checks with
// hand-derived constants sit alongside.
module tb_serial_pattern_matcher;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic din = 1'b0;
    logic mode = 1'b0;
    logic mask_in = 1'b1;
    logic clr = 1'b0;

    int   n_tests = 0;
    int   n_fail  = 0;
    string tag = "init";

    logic [7:0] sb_q[$];

    // Reference model state
    logic [7:0] m_win, m_pat, m_msk;
    int         m_fill, m_cnt;
    logic       m_match, m_sticky;

    serial_pattern_matcher_if bus ();

    assign bus.io_in = {2'b00, clr, mask_in, mode, din, rst_n, clk};

    serial_pattern_matcher #(
        .PAT_LEN       (8),
        .RESET_PATTERN (8'hA5),
        .CNT_W         (6)
    ) dut (
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string t, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", t, got, exp);
        end
    endtask

    task automatic model(input logic d, input logic md, input logic c, input logic r, input logic mi);
        logic [7:0] nw;
        logic       ok;
        if (!r) begin
            m_win = 8'h00; m_fill = 0; m_match = 1'b0; m_sticky = 1'b0; m_cnt = 0;
            m_pat = 8'hA5; m_msk = 8'hFF;
        end else if (md) begin
            m_pat = {m_pat[6:0], d};
`ifdef PATMATCH_MASK_EN
            m_msk = {m_msk[6:0], mi};
`endif
            m_win = 8'h00; m_fill = 0; m_match = 1'b0;
            if (c) begin m_cnt = 0; m_sticky = 1'b0; end
        end else begin
            nw = {m_win[6:0], d};
            ok = (m_fill >= 7);
            for (int k = 0; k < 8; k++)
                if (m_msk[k] && (nw[k] != m_pat[k])) ok = 1'b0;
            m_win = nw;
            m_fill = (m_fill < 8) ? m_fill + 1 : 8;
            m_match = ok;
            if (c) begin m_cnt = 0; m_sticky = 1'b0; end
            if (ok) begin
                m_sticky = 1'b1;
                if (m_cnt < 63) m_cnt++;
            end
        end
    endtask

    task automatic step(input logic d, input logic md, input logic c, input logic r, input logic mi);
        logic [7:0] exp;
        @(negedge clk);
        din = d; mode = md; clr = c; rst_n = r; mask_in = mi;
        model(d, md, c, r, mi);
        sb_q.push_back({6'(m_cnt), m_sticky, m_match});
        @(posedge clk);
        #1;
        exp = sb_q.pop_front();
        chk(tag, 32'(bus.io_out), 32'(exp));
    endtask

    initial begin
        logic [7:0] b, mk;
        int nm;

        // Reset
        tag = "reset";
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("reset_out", 32'(bus.io_out), 32'h0);

        // Default pattern A5, MSB first
        tag = "s1";
        b = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            step(b[7-i], 1'b0, 1'b0, 1'b1, 1'b1);
            chk("s1_pulse", 32'(bus.io_out[0]), 32'(i == 7));
        end
        chk("s1_sticky", 32'(bus.io_out[1]), 32'd1);
        chk("s1_count", 32'(bus.io_out[7:2]), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("s1_pulse_drop", 32'(bus.io_out[0]), 32'd0);

        // Load all-zero pattern (clear on first load cycle), then zeros
        tag = "s2";
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'(i == 0), 1'b1, 1'b1);
        chk("s2_load_clr", 32'(bus.io_out), 32'h0);
        nm = 0;
        for (int i = 0; i < 77; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            if (i < 7) chk("s2_fill_guard", 32'(bus.io_out[0]), 32'd0);
            else nm++;
            if (nm == 63 && i >= 7) chk("s2_cnt63", 32'(bus.io_out[7:2]), 32'd63);
        end
        chk("s2_cnt_sat", 32'(bus.io_out[7:2]), 32'd63);
        chk("s2_pulse", 32'(bus.io_out[0]), 32'd1);

        // Load 3C, detect overlapping stream
        tag = "s3";
        b = 8'h3C;
        for (int i = 0; i < 8; i++) step(b[7-i], 1'b1, 1'(i == 0), 1'b1, 1'b1);
        chk("s3_load", 32'(bus.io_out), 32'h0);
        for (int i = 0; i < 16; i++) begin
            step(b[7-(i%8)], 1'b0, 1'b0, 1'b1, 1'b1);
            chk("s3_pulse", 32'(bus.io_out[0]), 32'(i == 7 || i == 15));
        end
        chk("s3_count", 32'(bus.io_out[7:2]), 32'd2);
        b = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            step(b[7-i], 1'b0, 1'b0, 1'b1, 1'b1);
            chk("s3_no_a5", 32'(bus.io_out[0]), 32'd0);
        end
        chk("s3_count_hold", 32'(bus.io_out[7:2]), 32'd2);

        // Clear coinciding with a match, then clear alone mid-stream
        tag = "s4";
        b = 8'h3C;
        for (int i = 0; i < 8; i++) step(b[7-i], 1'b0, 1'(i == 7), 1'b1, 1'b1);
        chk("s4_clr_match", 32'(bus.io_out), 32'h07);
        for (int i = 0; i < 8; i++) begin
            step(b[7-i], 1'b0, 1'(i == 3), 1'b1, 1'b1);
            if (i == 3) chk("s4_clr_only", 32'(bus.io_out[7:1]), 32'd0);
        end
        chk("s4_rematch", 32'(bus.io_out), 32'h07);

        // Reset mid-stream restores A5 and empties the window
        tag = "s5";
        b = 8'hA5;
        for (int i = 0; i < 5; i++) step(b[7-i], 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("s5_reset", 32'(bus.io_out), 32'h0);
        for (int i = 5; i < 8; i++) begin
            step(b[7-i], 1'b0, 1'b0, 1'b1, 1'b1);
            chk("s5_no_match", 32'(bus.io_out[0]), 32'd0);
        end
        for (int i = 0; i < 8; i++) begin
            step(b[7-i], 1'b0, 1'b0, 1'b1, 1'b1);
            chk("s5_pulse", 32'(bus.io_out[0]), 32'(i == 7));
        end

        // Pattern A0 with mask F0 loaded together
        tag = "s6";
        b = 8'hA0;
        mk = 8'hF0;
        for (int i = 0; i < 8; i++) step(b[7-i], 1'b1, 1'b0, 1'b1, mk[7-i]);
        b = 8'hA7;
        for (int i = 0; i < 8; i++) step(b[7-i], 1'b0, 1'b0, 1'b1, 1'b1);
`ifdef PATMATCH_MASK_EN
        chk("s6_a7", 32'(bus.io_out[0]), 32'd1);
`else
        chk("s6_a7", 32'(bus.io_out[0]), 32'd0);
`endif
        b = 8'hB7;
        for (int i = 0; i < 8; i++) step(b[7-i], 1'b0, 1'b0, 1'b1, 1'b1);
        chk("s6_b7", 32'(bus.io_out[0]), 32'd0);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
